// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg: opcodes, control word layout and sequencer state shared by vec_mem_decoder
package vec_ctrl_pkg;

    localparam logic [5:0] OP_ARITH  = 6'b000000;
    localparam logic [5:0] OP_VARITH = 6'b100000;
    localparam logic [3:0] OP_IMM    = 4'b0010;
    localparam logic [5:0] OP_STR    = 6'b011000;
    localparam logic [5:0] OP_LDR    = 6'b011001;
    localparam logic [5:0] OP_BEQ    = 6'b001100;
    localparam logic [5:0] OP_BGT    = 6'b001101;
    localparam logic [5:0] OP_B      = 6'b000100;
    localparam logic [5:0] OP_STRV   = 6'b111000;
    localparam logic [5:0] OP_LDRV   = 6'b111001;

    localparam logic [1:0] IMM_NONE   = 2'b00;
    localparam logic [1:0] IMM_BRANCH = 2'b01;
    localparam logic [1:0] IMM_ARITH  = 2'b11;

    localparam logic [1:0] REG_SRC_RF  = 2'b00;
    localparam logic [1:0] REG_SRC_ALT = 2'b01;

    typedef struct packed {
        logic       reg_w;
        logic       reg_wv;
        logic       mem_to_reg;
        logic       mem_w;
        logic       mem_src;
        logic       mem_data;
        logic       mem_data_v;
        logic       vec_data;
        logic       branch;
        logic       alu_op;
        logic       alu_src;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
    } ctrl_word_t;

    typedef enum logic {IDLE, VBEAT} seq_state_t;

    function automatic logic is_vec_mem(input logic [5:0] op);
        return op == OP_STRV || op == OP_LDRV;
    endfunction

endpackage

// File: rtl/vec_ctrl_table.sv
// vec_ctrl_table: combinational opcode/func to control word decode with illegal-opcode flag
module vec_ctrl_table
    import vec_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [2:0] i_func,
    output ctrl_word_t o_ctrl,
    output logic       o_illegal
);

    logic w_arith_imm;

    assign w_arith_imm = i_func ==? 3'b?11;

    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        casez (i_opcode)
            OP_ARITH: begin
                o_ctrl.reg_w   = 1'b1;
                o_ctrl.alu_op  = 1'b1;
                o_ctrl.alu_src = w_arith_imm;
                o_ctrl.imm_src = w_arith_imm ? IMM_ARITH : IMM_NONE;
            end
            OP_VARITH: begin
                o_ctrl.reg_wv = 1'b1;
                o_ctrl.alu_op = 1'b1;
            end
            {OP_IMM, 2'b??}: begin
                o_ctrl.reg_w   = 1'b1;
                o_ctrl.alu_op  = 1'b1;
                o_ctrl.alu_src = 1'b1;
            end
            OP_STR: begin
                o_ctrl.mem_w   = 1'b1;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.reg_src = REG_SRC_ALT;
            end
            OP_LDR: begin
                o_ctrl.reg_w      = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_src    = 1'b1;
            end
            OP_BEQ, OP_BGT: begin
                o_ctrl.branch  = 1'b1;
                o_ctrl.alu_op  = 1'b1;
                o_ctrl.reg_src = REG_SRC_ALT;
            end
            OP_B: begin
                o_ctrl.branch  = 1'b1;
                o_ctrl.imm_src = IMM_BRANCH;
            end
            OP_STRV: begin
                o_ctrl.mem_w   = 1'b1;
                o_ctrl.mem_src = 1'b1;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.reg_src = REG_SRC_ALT;
            end
            // reg_wv for ldrv is added by the sequencer on the final beat only
            OP_LDRV: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.mem_src    = 1'b1;
                o_ctrl.vec_data   = 1'b1;
                o_ctrl.alu_src    = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vec_mem_decoder.sv
// vec_mem_decoder: registered main decoder with a multi-beat sequencer for vector loads/stores
module vec_mem_decoder
    import vec_ctrl_pkg::*;
#(
    parameter  int LANES  = 16,
    parameter  int LANE_W = 8,
    parameter  int MEM_W  = 32,
    localparam int BEATS  = LANES * LANE_W / MEM_W,
    localparam int BIDX_W = BEATS > 1 ? $clog2(BEATS) : 1,
    localparam int OFF_W  = LANES * LANE_W / 8 > 1 ? $clog2(LANES * LANE_W / 8) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode_i,
    input  logic [2:0]        func_i,
    input  logic              instr_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_ready_i,
    output logic              ctrl_valid_o,
    output logic              reg_w_o,
    output logic              reg_wv_o,
    output logic              mem_to_reg_o,
    output logic              mem_w_o,
    output logic              mem_src_o,
    output logic              mem_data_o,
    output logic              mem_data_v_o,
    output logic              vec_data_o,
    output logic              branch_o,
    output logic              alu_op_o,
    output logic              alu_src_o,
    output logic [1:0]        reg_src_o,
    output logic [1:0]        imm_src_o,
    output logic              illegal_o,
    output logic [BIDX_W-1:0] beat_idx_o,
    output logic [OFF_W-1:0]  addr_off_o,
    output logic              first_beat_o,
    output logic              last_beat_o,
    output logic              busy_o
);

    seq_state_t        r_state, w_state_nx;
    ctrl_word_t        r_ctrl, w_ctrl_nx, w_dec;
    logic              r_valid, w_valid_nx;
    logic              r_illegal, w_illegal_nx;
    logic              r_ldrv, w_ldrv_nx;
    logic [BIDX_W-1:0] r_beat, w_beat_nx;
    logic              w_dec_illegal, w_last, w_accept;

    vec_ctrl_table u_table (
        .i_opcode  (opcode_i),
        .i_func    (func_i),
        .o_ctrl    (w_dec),
        .o_illegal (w_dec_illegal)
    );

    // Scalar words sit in IDLE, so they are always their own last beat
    assign w_last   = r_state == IDLE || r_beat == BIDX_W'(BEATS - 1);
    assign busy_o   = r_state == VBEAT && !(w_last && mem_ready_i && !stall_i);
    assign w_accept = instr_valid_i && !busy_o && !stall_i && !flush_i;

    always_comb begin
        w_state_nx   = r_state;
        w_ctrl_nx    = r_ctrl;
        w_valid_nx   = r_valid;
        w_illegal_nx = r_illegal;
        w_ldrv_nx    = r_ldrv;
        w_beat_nx    = r_beat;
        if (flush_i) begin
            w_state_nx   = IDLE;
            w_ctrl_nx    = '0;
            w_valid_nx   = 1'b0;
            w_illegal_nx = 1'b0;
            w_ldrv_nx    = 1'b0;
            w_beat_nx    = '0;
        end else if (!stall_i) begin
            if (busy_o) begin
                w_beat_nx = r_beat + BIDX_W'(mem_ready_i);
            end else begin
                w_state_nx   = w_accept && is_vec_mem(opcode_i) && BEATS > 1 ? VBEAT : IDLE;
                w_ctrl_nx    = w_accept ? w_dec : '0;
                w_valid_nx   = w_accept;
                w_illegal_nx = w_accept && w_dec_illegal;
                w_ldrv_nx    = w_accept && opcode_i == OP_LDRV;
                w_beat_nx    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_ldrv    <= 1'b0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ctrl    <= w_ctrl_nx;
            r_valid   <= w_valid_nx;
            r_illegal <= w_illegal_nx;
            r_ldrv    <= w_ldrv_nx;
            r_beat    <= w_beat_nx;
        end
    end

    assign ctrl_valid_o = r_valid;
    assign reg_w_o      = r_ctrl.reg_w;
    assign reg_wv_o     = r_ctrl.reg_wv | (r_ldrv & w_last);
    assign mem_to_reg_o = r_ctrl.mem_to_reg;
    assign mem_w_o      = r_ctrl.mem_w;
    assign mem_src_o    = r_ctrl.mem_src;
    assign mem_data_o   = r_ctrl.mem_data;
    assign mem_data_v_o = r_ctrl.mem_data_v;
    assign vec_data_o   = r_ctrl.vec_data;
    assign branch_o     = r_ctrl.branch;
    assign alu_op_o     = r_ctrl.alu_op;
    assign alu_src_o    = r_ctrl.alu_src;
    assign reg_src_o    = r_ctrl.reg_src;
    assign imm_src_o    = r_ctrl.imm_src;
    assign illegal_o    = r_illegal;
    assign beat_idx_o   = r_beat;
    assign addr_off_o   = OFF_W'(r_beat) * OFF_W'(MEM_W / 8);
    assign first_beat_o = r_valid && r_beat == '0;
    assign last_beat_o  = r_valid && w_last;

endmodule

// File: tb/tb_vec_mem_decoder.sv
// tb_vec_mem_decoder: directed plan steps plus random traffic against a beat-count reference model
module tb_vec_mem_decoder;

    localparam int BEATS = 4;
    localparam int BPB   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode_i;
    logic [2:0] func_i;
    logic       instr_valid_i, stall_i, flush_i, mem_ready_i;
    logic       ctrl_valid_o, reg_w_o, reg_wv_o, mem_to_reg_o, mem_w_o, mem_src_o;
    logic       mem_data_o, mem_data_v_o, vec_data_o, branch_o, alu_op_o, alu_src_o;
    logic [1:0] reg_src_o, imm_src_o;
    logic       illegal_o;
    logic [1:0] beat_idx_o;
    logic [3:0] addr_off_o;
    logic       first_beat_o, last_beat_o, busy_o;

    int checks = 0;
    int failures = 0;

    bit         m_valid, m_vec;
    logic [5:0] m_op;
    logic [2:0] m_fn;
    int         m_beat, m_left;

    logic [5:0] ops [12] = '{6'b000000, 6'b100000, 6'b001001, 6'b011000, 6'b011001, 6'b001100,
                             6'b001101, 6'b000100, 6'b111000, 6'b111001, 6'b010101, 6'b111111};

    vec_mem_decoder dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .func_i(func_i),
        .instr_valid_i(instr_valid_i), .stall_i(stall_i), .flush_i(flush_i), .mem_ready_i(mem_ready_i),
        .ctrl_valid_o(ctrl_valid_o), .reg_w_o(reg_w_o), .reg_wv_o(reg_wv_o), .mem_to_reg_o(mem_to_reg_o),
        .mem_w_o(mem_w_o), .mem_src_o(mem_src_o), .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o),
        .vec_data_o(vec_data_o), .branch_o(branch_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
        .reg_src_o(reg_src_o), .imm_src_o(imm_src_o), .illegal_o(illegal_o), .beat_idx_o(beat_idx_o),
        .addr_off_o(addr_off_o), .first_beat_o(first_beat_o), .last_beat_o(last_beat_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // {valid, reg_w, reg_wv, mem_to_reg, mem_w, mem_src, mem_data, mem_data_v, vec_data, branch, alu_op, alu_src, reg_src, imm_src, illegal}
    function automatic logic [16:0] exp_ctrl(bit v, logic [5:0] op, logic [2:0] fn, int left);
        bit arith, varith, imm, str, ldr, beq, bgt, b, strv, ldrv, known, ai;
        arith  = op == 6'b000000;
        varith = op == 6'b100000;
        imm    = op[5:2] == 4'b0010;
        str    = op == 6'b011000;
        ldr    = op == 6'b011001;
        beq    = op == 6'b001100;
        bgt    = op == 6'b001101;
        b      = op == 6'b000100;
        strv   = op == 6'b111000;
        ldrv   = op == 6'b111001;
        known  = arith | varith | imm | str | ldr | beq | bgt | b | strv | ldrv;
        ai     = arith && fn[1:0] == 2'b11;
        if (!v) return '0;
        return {1'b1, arith | imm | ldr, varith | (ldrv && left == 0), ldr | ldrv, str | strv,
                strv | ldrv, 1'b0, 1'b0, ldrv, beq | bgt | b, arith | varith | imm | beq | bgt,
                ai | imm | str | ldr | strv | ldrv, 1'b0, str | beq | bgt | strv, ai, ai | b, !known};
    endfunction

    function automatic logic [7:0] exp_seq();
        if (!m_valid) return '0;
        return {2'(m_beat), 4'(m_beat * BPB), m_beat == 0, m_left == 0};
    endfunction

    function automatic logic [16:0] obs_ctrl();
        return {ctrl_valid_o, reg_w_o, reg_wv_o, mem_to_reg_o, mem_w_o, mem_src_o, mem_data_o,
                mem_data_v_o, vec_data_o, branch_o, alu_op_o, alu_src_o, reg_src_o, imm_src_o, illegal_o};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0;
        m_vec   = 0;
        m_beat  = 0;
        m_left  = 0;
    endtask

    task automatic step(string tag, bit iv, logic [5:0] op, logic [2:0] fn, bit rdy, bit st, bit fl);
        bit eb;
        bit isv;
        instr_valid_i = iv;
        opcode_i      = op;
        func_i        = fn;
        mem_ready_i   = rdy;
        stall_i       = st;
        flush_i       = fl;
        #2;
        eb = m_valid && m_vec && !(m_left == 0 && rdy && !st);
        chk({tag, ".busy"}, 32'(busy_o), 32'(eb));
        @(posedge clk);
        #1;
        isv = op == 6'b111000 || op == 6'b111001;
        if (fl) model_clear();
        else if (!st) begin
            if (eb) begin
                if (rdy) begin
                    m_beat++;
                    m_left--;
                end
            end else if (iv) begin
                m_valid = 1;
                m_op    = op;
                m_fn    = fn;
                m_vec   = isv;
                m_beat  = 0;
                m_left  = isv ? BEATS - 1 : 0;
            end else model_clear();
        end
        chk({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(m_valid, m_op, m_fn, m_left)));
        chk({tag, ".seq"}, 32'({beat_idx_o, addr_off_o, first_beat_o, last_beat_o}), 32'(exp_seq()));
    endtask

    initial begin
        rst = 1'b1;
        instr_valid_i = 0; opcode_i = '0; func_i = '0; stall_i = 0; flush_i = 0; mem_ready_i = 0;
        model_clear();
        m_op = '0;
        m_fn = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.ctrl", 32'(obs_ctrl()), 32'h0);
        chk("reset.seq", 32'({beat_idx_o, addr_off_o, first_beat_o, last_beat_o, busy_o}), 32'h0);
        rst = 1'b0;

        step("arith_imm", 1, 6'b000000, 3'b011, 1, 0, 0);
        chk("arith_imm.fields", 32'({ctrl_valid_o, reg_w_o, alu_src_o, imm_src_o, busy_o}), 32'b111110);
        step("idle", 0, 6'b000000, 3'b000, 1, 0, 0);

        step("ldrv.acc", 1, 6'b111001, 3'b000, 1, 0, 0);
        step("ldrv.b1", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("ldrv.b2", 0, 6'b000000, 3'b000, 1, 0, 0);
        chk("ldrv.b2.wv", 32'({beat_idx_o, addr_off_o, reg_wv_o}), 32'({2'd2, 4'd8, 1'b0}));
        step("ldrv.b3", 0, 6'b000000, 3'b000, 1, 0, 0);
        chk("ldrv.b3.wv", 32'({beat_idx_o, addr_off_o, reg_wv_o, last_beat_o}), 32'({2'd3, 4'd12, 2'b11}));
        step("ldrv.next", 1, 6'b001001, 3'b000, 1, 0, 0);

        step("strv.acc", 1, 6'b111000, 3'b000, 1, 0, 0);
        step("strv.b1", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("strv.hold1", 0, 6'b000000, 3'b000, 0, 0, 0);
        step("strv.hold2", 1, 6'b000000, 3'b000, 0, 0, 0);
        chk("strv.hold.mem_w", 32'({beat_idx_o, mem_w_o, busy_o}), 32'({2'd1, 2'b11}));
        step("strv.b2", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("strv.b3", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("strv.done", 0, 6'b000000, 3'b000, 1, 0, 0);

        step("fl.acc", 1, 6'b111000, 3'b000, 1, 0, 0);
        step("fl.b1", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("fl.b2", 0, 6'b000000, 3'b000, 1, 0, 0);
        step("fl.flush", 1, 6'b011001, 3'b000, 1, 0, 1);
        chk("fl.cleared", 32'({ctrl_valid_o, busy_o, beat_idx_o}), 32'h0);
        step("fl.next", 1, 6'b011001, 3'b000, 1, 0, 0);

        step("st.ldr", 1, 6'b011001, 3'b000, 1, 0, 0);
        step("st.s1", 1, 6'b000100, 3'b000, 1, 1, 0);
        step("st.s2", 1, 6'b000100, 3'b000, 1, 1, 0);
        step("st.s3", 1, 6'b000100, 3'b000, 1, 1, 0);
        chk("st.frozen", 32'({ctrl_valid_o, reg_w_o, mem_to_reg_o, branch_o}), 32'b1110);
        step("st.release", 1, 6'b000100, 3'b000, 1, 0, 0);

        step("ill", 1, 6'b010101, 3'b111, 1, 0, 0);
        chk("ill.only", 32'(obs_ctrl()), 32'h10001);
        step("ill.clear", 0, 6'b000000, 3'b000, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(3) != 0, ops[$urandom_range(11)], 3'($urandom),
                 $urandom_range(3) != 0, $urandom_range(9) == 0, $urandom_range(19) == 0);
        end

        step("ar.acc", 1, 6'b111001, 3'b000, 1, 0, 0);
        step("ar.b1", 0, 6'b000000, 3'b000, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("ar.ctrl", 32'(obs_ctrl()), 32'h0);
        chk("ar.seq", 32'({beat_idx_o, addr_off_o, first_beat_o, last_beat_o, busy_o}), 32'h0);
        model_clear();
        #2;
        rst = 1'b0;
        step("ar.after", 1, 6'b100000, 3'b000, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
